// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
// Command handshake between a caller and the PS/2 host transmitter.
//   tx_data  : command byte, sampled on the accepting edge
//   tx_valid : request; accepted on an edge where tx_valid & tx_ready
//   tx_ready : transmitter idle and able to take a byte
//   busy     : a frame is in progress
//   tx_done  : one-cycle pulse, frame sent and ACK received
//   tx_err   : one-cycle pulse, missing ACK or timeout
// master = caller side, slave = transmitter side.
`timescale 1ns/1ps
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, tx_valid,
                  input  tx_ready, busy, tx_done, tx_err);
  modport slave  (input  tx_data, tx_valid,
                  output tx_ready, busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte per request using
// the host request sequence: clock inhibit, request-to-send, shifting data on
// device clock falls (LSB first, odd parity, stop), then the device ACK check.
// Pad outputs are open-drain enables: 1 pulls the line low.
// Ports:
//   clk         : system clock
//   rst         : synchronous reset, active low
//   ps2_clk_i   : raw PS/2 clock pad level (asynchronous)
//   ps2_data_i  : raw PS/2 data pad level (asynchronous)
//   ps2_clk_oe  : 1 = drive PS/2 clock low
//   ps2_data_oe : 1 = drive PS/2 data low
//   tx          : command handshake (ps2_host_tx_if.slave)
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  ps2_host_tx_if.slave tx
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_REL
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic             r_clk_s1, r_clk_s2, r_clk_hist;
  logic             r_dat_s1, r_dat_s2;
  state_t           r_state, w_state_nxt;
  logic [8:0]       r_shift, w_shift_nxt;
  logic [3:0]       r_fall_cnt, w_fall_nxt;
  logic [INH_W-1:0] r_inh_cnt, w_inh_nxt;
  logic [TO_W-1:0]  r_to_cnt, w_to_nxt;
  logic             r_clk_oe, w_clk_oe_nxt;
  logic             r_data_oe, w_data_oe_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic       w_fall;
  logic [3:0] w_fall_inc;
  logic       w_ready;
  logic       w_accept;
  logic       w_timed;

  // Synchroniser stage: two flops per pad plus a clock history flop
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_i;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= ps2_data_i;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall     = r_clk_hist & ~r_clk_s2;
  assign w_fall_inc = r_fall_cnt + 4'd1;
  // The cycle carrying a done/err pulse is already IDLE but not yet ready,
  // so a new byte can only be taken once the pulse has gone.
  assign w_ready    = (r_state == S_IDLE) & ~r_done & ~r_err;
  assign w_accept   = tx.tx_valid & w_ready;
  assign w_timed    = (r_state == S_SEND) || (r_state == S_ACK) ||
                      (r_state == S_WAIT_REL);

  // Control stage: state, counters and registered pad enables
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fall_cnt <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fall_cnt <= w_fall_nxt;
      r_inh_cnt  <= w_inh_nxt;
      r_to_cnt   <= w_to_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
    r_shift <= w_shift_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_fall_nxt    = r_fall_cnt;
    w_inh_nxt     = r_inh_cnt;
    w_to_nxt      = r_to_cnt;
    // Pad clock enable lags the state by one cycle so the inhibit window
    // starts on the edge after acceptance.
    w_clk_oe_nxt  = (r_state == S_INHIBIT) || (r_state == S_REQ);
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_data_oe_nxt = 1'b0;
        if (w_accept) begin
          w_shift_nxt = {odd_parity(tx.tx_data), tx.tx_data};
          w_fall_nxt  = '0;
          w_to_nxt    = '0;
          w_inh_nxt   = '0;
          w_state_nxt = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_data_oe_nxt = 1'b0;
        if (r_inh_cnt == INH_LAST) w_state_nxt = S_REQ;
        else                       w_inh_nxt   = r_inh_cnt + 1'b1;
      end
      S_REQ: begin
        w_data_oe_nxt = 1'b1;  // start bit
        w_state_nxt   = S_SEND;
      end
      S_SEND: begin
        if (w_fall) begin
          w_fall_nxt = w_fall_inc;
          if (w_fall_inc == 4'd10) begin
            w_data_oe_nxt = 1'b0;  // stop bit: release the line
            w_state_nxt   = S_ACK;
          end else begin
            // Fall n presents shift bit n-1, i.e. the pre-increment count.
            w_data_oe_nxt = ~r_shift[r_fall_cnt];
          end
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_fall_nxt = w_fall_inc;
          if (!r_dat_s2) begin
            w_state_nxt = S_WAIT_REL;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT_REL: begin
        if (r_clk_s2 && r_dat_s2) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Timeout overrides anything the device did in the same cycle.
    if (w_timed) begin
      if (r_to_cnt == TO_LAST) begin
        w_state_nxt   = S_IDLE;
        w_data_oe_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b1;
      end else begin
        w_to_nxt = r_to_cnt + 1'b1;
      end
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx.tx_ready = w_ready;
  assign tx.busy     = (r_state != S_IDLE);
  assign tx.tx_done  = r_done;
  assign tx.tx_err   = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH      = 20;
  localparam int TO_MAIN  = 2000;
  localparam int TO_SHORT = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance with a device model on the wired-AND pads
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  logic clk_oe, data_oe, pclk, pdat;
  ps2_host_tx_if tif ();
  assign pclk = ~clk_oe & dev_clk;
  assign pdat = ~data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO_MAIN)) dut (
    .clk(clk), .rst(rst), .ps2_clk_i(pclk), .ps2_data_i(pdat),
    .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe), .tx(tif));

  // Short-timeout instance whose device never clocks
  logic clk_oe2, data_oe2, pclk2, pdat2;
  ps2_host_tx_if tif2 ();
  assign pclk2 = ~clk_oe2;
  assign pdat2 = ~data_oe2;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO_SHORT)) dut_to (
    .clk(clk), .rst(rst), .ps2_clk_i(pclk2), .ps2_data_i(pdat2),
    .ps2_clk_oe(clk_oe2), .ps2_data_oe(data_oe2), .tx(tif2));

  int checks = 0;
  int errors = 0;
  int dev_falls = 0;

  // Monitors
  int cyc = 0;
  int n_done = 0, n_err = 0, n_both = 0;
  int oe_run = 0, last_oe_run = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tif.tx_done) n_done <= n_done + 1;
    if (tif.tx_err)  n_err  <= n_err + 1;
    if (tif.tx_done && tif.tx_err) n_both <= n_both + 1;
    if (clk_oe) oe_run <= oe_run + 1;
    else if (oe_run != 0) begin
      last_oe_run <= oe_run;
      oe_run      <= 0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame as the device should see it: start, LSB-first data,
  // odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_byte(input logic [7:0] b);
    bit got;
    bit r;
    got = 0;
    dev_falls = 0;
    tif.tx_data  = b;
    tif.tx_valid = 1'b1;
    for (int i = 0; i < 500 && !got; i++) begin
      r = tif.tx_ready;
      step();
      if (r) got = 1;
    end
    tif.tx_valid = 1'b0;
    if (!got) chk("accept_wait", 32'd0, 32'd1);
  endtask

  // Device: waits for request-to-send, samples start, then generates clocks
  // (8 low / 8 high), sampling data on each rising edge.
  task automatic dev_frame(input bit ack_en, input int stop_after, output logic [10:0] s);
    bit seen;
    s = '1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (!clk_oe && data_oe) seen = 1;
    end
    if (!seen) begin
      chk("dev_rts_wait", 32'd0, 32'd1);
      return;
    end
    repeat (4) step();
    s[0] = pdat;
    for (int i = 1; i <= 11; i++) begin
      if (i > stop_after) break;
      dev_clk   = 1'b0;
      dev_falls = i;
      repeat (8) step();
      dev_clk = 1'b1;
      if (i <= 10) s[i] = pdat;
      if (i == 10 && ack_en) begin
        repeat (2) step();
        dev_data = 1'b0;
        repeat (6) step();
      end else if (i == 11) begin
        repeat (2) step();
        dev_data = 1'b1;
        repeat (6) step();
      end else begin
        repeat (8) step();
      end
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] b, input bit ack,
                           input bit exp_par, input int exp_d, input int exp_e);
    logic [10:0] s;
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    start_byte(b);
    dev_frame(ack, 11, s);
    repeat (6) step();
    chk({nm, "_bits"},    32'(s), 32'(model_frame(b)));
    chk({nm, "_parity"},  32'(s[9]), 32'(exp_par));
    chk({nm, "_inhibit"}, last_oe_run, INH + 1);
    chk({nm, "_done"},    n_done - d0, exp_d);
    chk({nm, "_err"},     n_err - e0, exp_e);
    chk({nm, "_idle"},    {clk_oe, data_oe, tif.tx_ready, tif.busy}, 4'b0010);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [10:0] s;
    int d0, e0, t0, t1;
    bit hit;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{8'hF4, 1'b1, 1'b0, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 0};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 0, 1};

    tif2.tx_data  = 8'h55;
    tif2.tx_valid = 1'b0;

    // Reset held with a pending request
    tif.tx_data  = 8'hF4;
    tif.tx_valid = 1'b1;
    rst = 1'b0;
    repeat (5) begin
      step();
      chk("rst_state", {clk_oe, data_oe, tif.tx_ready, tif.busy, tif.tx_done, tif.tx_err},
          6'b001000);
    end
    rst = 1'b1;
    step();
    chk("rst_first_accept", {clk_oe, tif.busy, tif.tx_ready}, 3'b010);
    tif.tx_valid = 1'b0;
    dev_falls = 0;
    dev_frame(1'b1, 11, s);
    repeat (6) step();
    chk("rst_frame_bits", 32'(s), 32'(model_frame(8'hF4)));
    chk("rst_frame_done", n_done, 1);

    // Table-driven frames
    for (int k = 0; k < 6; k++)
      run_frame($sformatf("vec%0d_%02h", k, vecs[k].data), vecs[k].data, vecs[k].ack,
                vecs[k].exp_par, vecs[k].exp_done, vecs[k].exp_err);

    // Randomized frames against the reference model
    for (int k = 0; k < 6; k++) begin
      logic [7:0]  b;
      bit          a;
      logic [10:0] m;
      b = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      m = model_frame(b);
      run_frame($sformatf("rnd%0d_%02h", k, b), b, a, m[9], int'(a), int'(!a));
    end

    // Request while busy is ignored
    d0 = n_done;
    e0 = n_err;
    start_byte(8'hF4);
    fork
      dev_frame(1'b1, 11, s);
      begin
        for (int i = 0; i < 2000 && dev_falls < 4; i++) step();
        repeat (4) step();
        tif.tx_data  = 8'hAA;
        tif.tx_valid = 1'b1;
        step();
        tif.tx_valid = 1'b0;
      end
    join
    repeat (6) step();
    chk("busy_bits", 32'(s), 32'(model_frame(8'hF4)));
    chk("busy_done", n_done - d0, 1);
    chk("busy_err", n_err - e0, 0);
    repeat (30) step();
    chk("busy_no_requeue", {tif.busy, clk_oe, tif.tx_ready}, 3'b001);

    // Reset in the middle of a frame
    start_byte(8'h00);
    dev_frame(1'b1, 6, s);
    chk("mid_pre_data_oe", {tif.busy, data_oe}, 2'b11);
    d0 = n_done;
    e0 = n_err;
    rst = 1'b0;
    step();
    chk("mid_rst_release", {clk_oe, data_oe, tif.busy}, 3'b000);
    rst = 1'b1;
    repeat (20) step();
    chk("mid_rst_pulses", (n_done - d0) + (n_err - e0), 0);
    chk("mid_rst_idle", {clk_oe, data_oe, tif.tx_ready}, 3'b001);

    // Timeout on the short-timeout instance
    tif2.tx_valid = 1'b1;
    step();
    tif2.tx_valid = 1'b0;
    hit = 0;
    t0 = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      if (!clk_oe2) begin
        hit = 1;
        t0 = cyc;
      end
    end
    chk("to_clk_release", 32'(hit), 32'd1);
    hit = 0;
    t1 = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (tif2.tx_err) begin
        hit = 1;
        t1 = cyc;
      end else begin
        step();
      end
    end
    chk("to_err_seen", 32'(hit), 32'd1);
    chk("to_latency", t1 - t0, TO_SHORT);
    chk("to_oe_released", {clk_oe2, data_oe2, tif2.tx_done}, 3'b000);
    step();
    chk("to_ready_after", {tif2.tx_ready, tif2.busy, tif2.tx_err}, 3'b100);

    chk("never_done_and_err", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
